mdl_bdy_but_pwm: RTL and testbench
==================================

MDL_BDY_BUT_PWM -- requirements
Module: mdl_bdy_but_pwm

Interface
REQ-001 The module SHALL have parameter PRM_DAXI, default 64, AXI-Stream data width: two 32-bit coefficients per beat.
REQ-002 The module SHALL have parameter PRM_ADDR, default 12, internal buffer address width.
REQ-003 The module SHALL have parameter PRM_DRAM, default 32, coefficient and buffer word width.
REQ-004 The module SHALL have parameter PRM_COEFFS, default 16, coefficients per polynomial; it SHALL be even and ≤ 2^PRM_ADDR.
REQ-005 The module SHALL have port iSYS_CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port iSYS_RST, input, 1 bit, reset; synchronous, active-high.
REQ-007 The module SHALL have port iFSM_MODE, input, 3 bits: 0 = PWM, 1 = NTT, 2 = INTT.
REQ-008 The module SHALL have port iFSM_START, input, 1 bit, start request.
REQ-009 The module SHALL have port iCTL_Q, input, 2 bits, modulus select.
REQ-010 The module SHALL have port iCTL_NTT_Depth, input, 5 bits, reserved; ignored in this block.
REQ-011 The module SHALL have the input stream slave iRs_Tvalid (in, 1), oRs_Tready (out, 1), iRs_Tdata (in, PRM_DAXI) and iRs_Tlast (in, 1).
REQ-012 The module SHALL have the output stream master oWm_Tvalid (out, 1), iWm_Tready (in, 1), oWm_Tdata (out, PRM_DAXI) and oWm_Tlast (out, 1).

Function
REQ-013 The module SHALL implement the FSM states IDLE, LOAD_A, LOAD_B, CALC, OUT.
REQ-014 In IDLE, a rising edge of iFSM_START with iFSM_MODE=0 SHALL go to LOAD_A; any other mode SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-015 Start SHALL be edge-detected, so a held-high iFSM_START never re-triggers.
REQ-016 oRs_Tready SHALL be 1 exactly in LOAD_A and LOAD_B; a beat transfers when iRs_Tvalid and oRs_Tready are both 1.
REQ-017 LOAD_A SHALL accept PRM_COEFFS/2 beats; beat k stores A[2k]=Tdata[31:0] and A[2k+1]=Tdata[63:32]. It SHALL then go to LOAD_B.
REQ-018 LOAD_B SHALL accept PRM_COEFFS beats; beat j stores B[j]=Tdata[31:0], and Tdata[63:32] is ignored. It SHALL then go to CALC.
REQ-019 Beat counting alone SHALL end loading; iRs_Tlast SHALL be ignored.
REQ-020 Beats offered after the last accepted beat SHALL see oRs_Tready=0 and SHALL not be consumed.
REQ-021 CALC SHALL compute C[i] = (A[i]·B[i]) mod q for i = 0..PRM_COEFFS-1.
REQ-022 The product SHALL be the full 64-bit product.
REQ-023 The result SHALL be exact for any 32-bit A[i] and B[i], and SHALL lie in [0, q).
REQ-024 q SHALL be selected by iCTL_Q, sampled at start: 0 → Q1, 1 → Q2, 2 and 3 → Q1.
REQ-025 CALC SHALL take at most PRM_COEFFS+8 cycles; C SHALL be stored in an internal buffer, then the FSM SHALL go to OUT.
REQ-026 OUT SHALL emit PRM_COEFFS/2 beats with oWm_Tdata = {C[2k+1], C[2k]}.
REQ-027 oWm_Tlast SHALL be 1 only on the final beat of OUT.
REQ-028 While oWm_Tvalid=1 and iWm_Tready=0, oWm_Tdata, oWm_Tlast and oWm_Tvalid SHALL hold stable.
REQ-029 After the last output handshake the FSM SHALL return to IDLE, with oWm_Tvalid=0 the next cycle.
REQ-030 iFSM_START edges outside IDLE SHALL be ignored.
REQ-031 A new PWM SHALL be able to start the cycle after return to IDLE.

Reset
REQ-032 When iSYS_RST=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-load or mid-output.
REQ-033 On reset, the counters and the start-edge register SHALL clear.
REQ-034 On reset, oRs_Tready, oWm_Tvalid and oWm_Tlast SHALL be 0 and oWm_Tdata SHALL be 0.
REQ-035 Buffer contents SHALL not be cleared by reset.

Structure
REQ-036 A shared package SHALL hold the Q1/Q2 constants, the FSM state encoding and the mode codes (PWM=0, NTT=1, INTT=2).
REQ-037 The modular multiplier SHALL be one sub-module, mdl_modmul (a, b, q in; r out; fixed pipeline latency).
REQ-038 The A, B and C buffers SHALL be PRM_DRAM-wide, 2^PRM_ADDR-deep register or BRAM arrays inside the top module.

Verification
REQ-039 Basic PWM, defaults, iCTL_Q=0: A beats k=0..7 carry {k+1, k+1}; B beats carry 9..24 in the low word. The 8 output beats SHALL be {(k+1)(10+2k), (k+1)(9+2k)}, i.e. beat0={10,9} and beat7={192,184}, with Tlast only on beat7.
REQ-040 Backpressure: hold iWm_Tready=0 through CALC, then toggle it every cycle. Output data SHALL stay stable while stalled, and exactly 8 beats SHALL be delivered in order.
REQ-041 Extra input: an additional beat with Tlast=1 after the 24th beat SHALL not be accepted (oRs_Tready=0), and the results SHALL be unchanged.
REQ-042 Reduction: A[0]=B[0]=Q1-1 SHALL give C[0]=1; A[0]=2^32-1, B[0]=2^32-1 SHALL give C[0]=((2^32-1)^2) mod Q1. The same checks SHALL be repeated with iCTL_Q=1 and Q2.
REQ-043 Mode and start: iFSM_MODE=1 with a start edge SHALL keep oRs_Tready=0. iFSM_START held high after completion SHALL not begin a second run.
REQ-044 Reset mid-LOAD_B (after 12 beats): outputs SHALL go to 0 and the state to IDLE. A following full PWM SHALL give the REQ-039 results.

Source files
------------

// File: rtl/mdl_bdy_but_pwm_pkg.sv
// Shared constants and encodings for the point-wise modular multiplier.
// Both moduli must exceed 2^31 so the multiplier's first fold needs one subtract.
package mdl_bdy_but_pwm_pkg;

  localparam logic [31:0] Q1 = 32'd4294967291;
  localparam logic [31:0] Q2 = 32'd3221225473;

  localparam int MODMUL_LAT = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CALC   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    MODE_PWM  = 3'd0,
    MODE_NTT  = 3'd1,
    MODE_INTT = 3'd2
  } mode_t;

  function automatic logic [31:0] q_select(
    input logic [1:0] sel
  );
    logic [31:0] q;
    unique case (1'b1)
      sel == 2'd1: q = Q2;
      default:     q = Q1;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/mdl_bdy_but_pwm_modmul.sv
// Pipelined (a*b) mod q: multiply, fold the high word, then shift-subtract
// the low word eight bits per stage. Requires q > 2^(W-1).
module mdl_modmul
  import mdl_bdy_but_pwm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] r_o
);

  localparam int NST = MODMUL_LAT - 2;
  localparam int SPS = W / NST;

  logic [2*W-1:0] p_q;
  logic [W-1:0]   pm_q;
  logic [W-1:0]   hi;
  logic [W-1:0]   r_q [NST+1];
  logic [W-1:0]   l_q [NST];
  logic [W-1:0]   m_q [NST];

  assign hi = p_q[2*W-1:W];

  function automatic logic [W-1:0] step(
    input logic [W-1:0]   r,
    input logic [SPS-1:0] bits,
    input logic [W-1:0]   q
  );
    logic [W:0]   t;
    logic [W-1:0] acc;
    acc = r;
    for (int k = SPS - 1; k >= 0; k--) begin
      t = {acc, bits[k]};
      if (t >= {1'b0, q}) t = t - {1'b0, q};
      acc = t[W-1:0];
    end
    return acc;
  endfunction

  always_ff @(posedge clk_i) begin
    p_q    <= (2*W)'(a_i) * (2*W)'(b_i);
    pm_q   <= q_i;
    r_q[0] <= (hi >= pm_q) ? hi - pm_q : hi;
    l_q[0] <= p_q[W-1:0];
    m_q[0] <= pm_q;
    for (int s = 0; s < NST; s++) begin
      r_q[s+1] <= step(r_q[s], l_q[s][W-1-s*SPS -: SPS], m_q[s]);
      if (s < NST - 1) begin
        l_q[s+1] <= l_q[s];
        m_q[s+1] <= m_q[s];
      end
    end
  end

  assign r_o = r_q[NST];

endmodule

// File: rtl/mdl_bdy_but_pwm.sv
// Point-wise polynomial multiply: stream in A and B, compute A[i]*B[i] mod q,
// stream C back out two coefficients per beat.
module mdl_bdy_but_pwm
  import mdl_bdy_but_pwm_pkg::*;
#(
  parameter int PRM_DAXI   = 64,
  parameter int PRM_ADDR   = 12,
  parameter int PRM_DRAM   = 32,
  parameter int PRM_COEFFS = 16
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic [2:0]          iFSM_MODE,
  input  logic                iFSM_START,
  input  logic [1:0]          iCTL_Q,
  input  logic [4:0]          iCTL_NTT_Depth,
  input  logic                iRs_Tvalid,
  output logic                oRs_Tready,
  input  logic [PRM_DAXI-1:0] iRs_Tdata,
  input  logic                iRs_Tlast,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast
);

  localparam int CW    = PRM_ADDR + 1;
  localparam int HALF  = PRM_COEFFS / 2;
  localparam int DEPTH = 1 << PRM_ADDR;
  localparam int LAT   = MODMUL_LAT;

  state_t              st_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       iss_q;
  logic [CW-1:0]       wr_q;
  logic                start_q;
  logic [PRM_DRAM-1:0] q_q;
  logic                rdy_q;
  logic                vld_q;
  logic                last_q;
  logic [PRM_DAXI-1:0] dat_q;
  logic [LAT-1:0]      pv_q;

  logic [PRM_DRAM-1:0] a_mem [DEPTH];
  logic [PRM_DRAM-1:0] b_mem [DEPTH];
  logic [PRM_DRAM-1:0] c_mem [DEPTH];

  logic                start_rise;
  logic                rs_fire;
  logic                wm_fire;
  logic                iss_en;
  logic                a_we;
  logic                b_we;
  logic                c_we;
  logic [PRM_ADDR-1:0] ev_idx;
  logic [PRM_ADDR-1:0] od_idx;
  logic [PRM_ADDR-1:0] cnt_idx;
  logic [PRM_ADDR-1:0] iss_idx;
  logic [PRM_ADDR-1:0] wr_idx;
  logic [PRM_DRAM-1:0] mm_r;
  logic                unused_ok;

  assign unused_ok  = ^{iCTL_NTT_Depth, iRs_Tlast};

  assign start_rise = iFSM_START & ~start_q;
  assign rs_fire    = iRs_Tvalid & rdy_q;
  assign wm_fire    = vld_q & iWm_Tready;
  assign iss_en     = (st_q == ST_CALC) && (iss_q < CW'(PRM_COEFFS));

  assign ev_idx  = PRM_ADDR'({cnt_q, 1'b0});
  assign od_idx  = ev_idx | PRM_ADDR'(1);
  assign cnt_idx = cnt_q[PRM_ADDR-1:0];
  assign iss_idx = iss_q[PRM_ADDR-1:0];
  assign wr_idx  = wr_q[PRM_ADDR-1:0];

  assign a_we = ~iSYS_RST & rs_fire & (st_q == ST_LOAD_A);
  assign b_we = ~iSYS_RST & rs_fire & (st_q == ST_LOAD_B);
  assign c_we = ~iSYS_RST & pv_q[LAT-1] & (st_q == ST_CALC);

  mdl_modmul #(
    .W (PRM_DRAM)
  ) u_modmul (
    .clk_i (iSYS_CLK),
    .a_i   (a_mem[iss_idx]),
    .b_i   (b_mem[iss_idx]),
    .q_i   (q_q),
    .r_o   (mm_r)
  );

  // Buffers are deliberately left out of reset.
  always_ff @(posedge iSYS_CLK) begin
    if (a_we) begin
      a_mem[ev_idx] <= iRs_Tdata[PRM_DRAM-1:0];
      a_mem[od_idx] <= iRs_Tdata[2*PRM_DRAM-1:PRM_DRAM];
    end
    if (b_we) b_mem[cnt_idx] <= iRs_Tdata[PRM_DRAM-1:0];
    if (c_we) c_mem[wr_idx] <= mm_r;
  end

  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      iss_q   <= '0;
      wr_q    <= '0;
      start_q <= 1'b0;
      q_q     <= PRM_DRAM'(Q1);
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      dat_q   <= '0;
      pv_q    <= '0;
    end else begin
      start_q <= iFSM_START;
      pv_q    <= {pv_q[LAT-2:0], iss_en};
      unique case (st_q)
        ST_IDLE: begin
          if (start_rise && iFSM_MODE == MODE_PWM) begin
            st_q  <= ST_LOAD_A;
            rdy_q <= 1'b1;
            cnt_q <= '0;
            q_q   <= PRM_DRAM'(q_select(iCTL_Q));
          end
        end
        ST_LOAD_A: begin
          if (rs_fire) begin
            if (cnt_q == CW'(HALF - 1)) begin
              st_q  <= ST_LOAD_B;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (rs_fire) begin
            if (cnt_q == CW'(PRM_COEFFS - 1)) begin
              st_q  <= ST_CALC;
              rdy_q <= 1'b0;
              cnt_q <= '0;
              iss_q <= '0;
              wr_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (iss_en) iss_q <= iss_q + 1'b1;
          if (pv_q[LAT-1]) wr_q <= wr_q + 1'b1;
          // cnt_q is 0 here, so the indices address beat 0
          if (wr_q == CW'(PRM_COEFFS)) begin
            st_q   <= ST_OUT;
            vld_q  <= 1'b1;
            last_q <= (HALF == 1);
            dat_q  <= {c_mem[od_idx], c_mem[ev_idx]};
            cnt_q  <= CW'(1);
          end
        end
        ST_OUT: begin
          if (wm_fire) begin
            if (last_q) begin
              st_q   <= ST_IDLE;
              vld_q  <= 1'b0;
              last_q <= 1'b0;
            end else begin
              dat_q  <= {c_mem[od_idx], c_mem[ev_idx]};
              last_q <= (cnt_q == CW'(HALF - 1));
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign oRs_Tready = rdy_q;
  assign oWm_Tvalid = vld_q;
  assign oWm_Tlast  = last_q;
  assign oWm_Tdata  = dat_q;

endmodule

// File: tb/tb_mdl_bdy_but_pwm.sv
// Bench for mdl_bdy_but_pwm: vector table of full runs with a scoreboard,
// plus mode, held-start and mid-load reset sequences.
module tb_mdl_bdy_but_pwm;

  localparam longint unsigned Q1 = 64'd4294967291;
  localparam longint unsigned Q2 = 64'd3221225473;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        start = 1'b0;
  logic [1:0]  qsel = 2'd0;
  logic [4:0]  depth = 5'd0;
  logic        rs_valid = 1'b0;
  logic        rs_ready;
  logic [63:0] rs_data = '0;
  logic        rs_last = 1'b0;
  logic        wm_valid;
  logic        wm_ready = 1'b0;
  logic [63:0] wm_data;
  logic        wm_last;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    string       name;
    logic [1:0]  qs;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] c0;
    bit          bp;
    bit          extra;
  } vec_t;

  always #5 clk = ~clk;

  mdl_bdy_but_pwm dut (
    .iSYS_CLK       (clk),
    .iSYS_RST       (rst),
    .iFSM_MODE      (mode),
    .iFSM_START     (start),
    .iCTL_Q         (qsel),
    .iCTL_NTT_Depth (depth),
    .iRs_Tvalid     (rs_valid),
    .oRs_Tready     (rs_ready),
    .iRs_Tdata      (rs_data),
    .iRs_Tlast      (rs_last),
    .oWm_Tvalid     (wm_valid),
    .iWm_Tready     (wm_ready),
    .oWm_Tdata      (wm_data),
    .oWm_Tlast      (wm_last)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mm(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input longint unsigned q);
    longint unsigned pa = 64'(a);
    longint unsigned pb = 64'(b);
    return 32'((pa * pb) % q);
  endfunction

  task automatic send_beat(input string nm, input logic [63:0] d,
                           input logic l);
    int n = 0;
    rs_valid = 1'b1;
    rs_data  = d;
    rs_last  = l;
    @(negedge clk);
    while (!rs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rs_ready) check({nm, "_accept_timeout"}, 64'(rs_ready), 64'd1);
    tick();
    rs_valid = 1'b0;
    rs_last  = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] qs, input bit hold);
    qsel  = qs;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic collect(input string nm, input bit bp);
    int          cyc  = 0;
    int          got  = 0;
    bit          stl  = 0;
    bit          seen = 0;
    logic        rp   = 1'b0;
    logic [63:0] pd   = '0;
    logic        pl   = 1'b0;
    beat_t       e;
    while (sb.size() > 0 && cyc < 300) begin
      wm_ready = bp ? rp : 1'b1;
      @(negedge clk);
      if (stl) begin
        check({nm, "_stall_valid"}, 64'(wm_valid), 64'd1);
        check({nm, "_stall_data"}, wm_data, pd);
        check({nm, "_stall_last"}, 64'(wm_last), 64'(pl));
      end
      stl = 0;
      if (wm_valid) begin
        seen = 1;
        if (wm_ready) begin
          e = sb.pop_front();
          check({nm, "_data"}, wm_data, e.d);
          check({nm, "_last"}, 64'(wm_last), 64'(e.l));
          got++;
        end else begin
          stl = 1;
          pd  = wm_data;
          pl  = wm_last;
        end
      end
      tick();
      cyc++;
      if (bp && seen) rp = ~rp;
    end
    if (sb.size() > 0) begin
      check({nm, "_out_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    check({nm, "_beats"}, 64'(got), 64'd8);
    wm_ready = 1'b0;
    @(negedge clk);
    check({nm, "_idle_valid"}, 64'(wm_valid), 64'd0);
  endtask

  task automatic run_pwm(input vec_t v, input bit hold);
    logic [31:0]     a [16];
    logic [31:0]     b [16];
    logic [31:0]     c [16];
    longint unsigned q;
    beat_t           e;
    q = (v.qs == 2'd1) ? Q2 : Q1;
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i / 2 + 1);
      b[i] = 32'(9 + i);
    end
    a[0] = v.a0;
    b[0] = v.b0;
    for (int i = 0; i < 16; i++) c[i] = mm(a[i], b[i], q);
    c[0] = v.c0;
    for (int k = 0; k < 8; k++) begin
      e.d = {c[2*k+1], c[2*k]};
      e.l = (k == 7);
      sb.push_back(e);
    end
    pulse_start(v.qs, hold);
    for (int k = 0; k < 8; k++)
      send_beat(v.name, {a[2*k+1], a[2*k]}, 1'b0);
    for (int j = 0; j < 16; j++)
      send_beat(v.name, {32'hDEAD_0000 | 32'(j), b[j]}, j == 5);
    if (v.extra) begin
      rs_valid = 1'b1;
      rs_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      rs_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({v.name, "_extra_ready"}, 64'(rs_ready), 64'd0);
        tick();
      end
      rs_valid = 1'b0;
      rs_last  = 1'b0;
    end
    collect(v.name, v.bp);
  endtask

  vec_t vt [9];
  vec_t basic;

  initial begin
    basic = '{"basic", 2'd0, 32'd1, 32'd9, 32'd9, 1'b0, 1'b0};
    vt[0] = basic;
    vt[1] = '{"backpressure", 2'd0, 32'd1, 32'd9, 32'd9, 1'b1, 1'b0};
    vt[2] = '{"extra_beat", 2'd0, 32'd1, 32'd9, 32'd9, 1'b0, 1'b1};
    vt[3] = '{"q1_m1_sq", 2'd0, 32'(Q1 - 1), 32'(Q1 - 1), 32'd1,
              1'b0, 1'b0};
    vt[4] = '{"q1_ones_sq", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16,
              1'b0, 1'b0};
    vt[5] = '{"q2_m1_sq", 2'd1, 32'(Q2 - 1), 32'(Q2 - 1), 32'd1,
              1'b0, 1'b0};
    vt[6] = '{"q2_ones_sq", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd2863311537, 1'b0, 1'b0};
    vt[7] = '{"qsel2_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16,
              1'b0, 1'b0};
    vt[8] = '{"qsel3_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16,
              1'b0, 1'b0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(rs_ready), 64'd0);
    check("rst_valid", 64'(wm_valid), 64'd0);
    check("rst_last", 64'(wm_last), 64'd0);
    check("rst_data", wm_data, 64'd0);
    tick();

    for (int i = 0; i < 9; i++) run_pwm(vt[i], 1'b0);

    mode = 3'd1;
    pulse_start(2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ntt_mode_ready", 64'(rs_ready), 64'd0);
      tick();
    end
    mode = 3'd0;

    run_pwm(basic, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_start_ready", 64'(rs_ready), 64'd0);
      tick();
    end
    start = 1'b0;
    tick();

    pulse_start(2'd0, 1'b0);
    for (int k = 0; k < 8; k++)
      send_beat("rst_mid", {32'(k + 1), 32'(k + 1)}, 1'b0);
    for (int j = 0; j < 12; j++)
      send_beat("rst_mid", {32'h0, 32'(9 + j)}, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 64'(rs_ready), 64'd0);
    check("rst_mid_valid", 64'(wm_valid), 64'd0);
    check("rst_mid_last", 64'(wm_last), 64'd0);
    check("rst_mid_data", wm_data, 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_stay_idle", 64'(rs_ready), 64'd0);
      tick();
    end
    basic.name = "after_rst";
    run_pwm(basic, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
